// File: rtl/ps2_scancode_rx_if.sv
// Keyboard-side bundle for ps2_scancode_rx: raw PS/2 lines in, decoded byte and strobes out.
// The slave modport is the receiver; master is the keyboard/decoder side that drives the lines.
interface ps2_scancode_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scancode;
   logic       flag;
   logic       parity_err;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  scancode, flag, parity_err, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output scancode, flag, parity_err, frame_err
   );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronize, de-glitch, deframe 11-bit frames, check parity/stop.
// Optional break-code swallowing is enabled by defining PS2_BREAK_FILTER_EN.
module ps2_scancode_rx #(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 25000
) (
   input  logic              vga_clk,
   input  logic              reset,
   ps2_scancode_rx_if.slave  kbd
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

   logic         clk_m_q, clk_s_q, dat_m_q, dat_s_q;
   logic         clk_f_q, clk_f_d;
   logic         fall_q, fall_d;
   logic [7:0]   deb_q, deb_d;
   state_e       state_q, state_d;
   logic [2:0]   bit_q, bit_d;
   logic [7:0]   shift_q, shift_d;
   logic         par_ok_q, par_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]   code_q, code_d;
   logic         flag_q, flag_d;
   logic         perr_q, perr_d;
   logic         ferr_q, ferr_d;
`ifdef PS2_BREAK_FILTER_EN
   logic         brk_q, brk_d;
`endif

   // Synchronizers idle high, matching the PS/2 bus idle level
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         clk_m_q <= 1'b1;
         clk_s_q <= 1'b1;
         dat_m_q <= 1'b1;
         dat_s_q <= 1'b1;
      end else begin
         clk_m_q <= kbd.ps2_clk;
         clk_s_q <= clk_m_q;
         dat_m_q <= kbd.ps2_data;
         dat_s_q <= dat_m_q;
      end
   end

   always_comb begin
      deb_d   = deb_q;
      clk_f_d = clk_f_q;
      fall_d  = 1'b0;
      if (clk_s_q == clk_f_q) begin
         deb_d = 8'd0;
      end else if (deb_q == 8'(DEBOUNCE_CYCLES - 1)) begin
         deb_d   = 8'd0;
         clk_f_d = clk_s_q;
         fall_d  = ~clk_s_q;
      end else begin
         deb_d = deb_q + 8'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      code_d   = code_q;
      flag_d   = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_d    = brk_q;
`endif
      if (fall_q)
         tmo_d = '0;
      else if (state_q != S_IDLE && tmo_q != TW'(TIMEOUT_CYCLES))
         tmo_d = tmo_q + 1'b1;
      else
         tmo_d = tmo_q;

      case (state_q)
         S_IDLE: begin
            if (fall_q && !dat_s_q) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (fall_q) begin
               shift_d[bit_q] = dat_s_q;
               if (bit_q == 3'd7) state_d = S_PARITY;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         S_PARITY: begin
            if (fall_q) begin
               par_ok_d = (^shift_q) ^ dat_s_q;
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall_q) begin
               state_d = S_IDLE;
               if (!dat_s_q)
                  ferr_d = 1'b1;
               else if (!par_ok_q)
                  perr_d = 1'b1;
               else begin
`ifdef PS2_BREAK_FILTER_EN
                  // F0 arms the filter; the byte after it is the released key and is dropped
                  if (brk_q)
                     brk_d = 1'b0;
                  else if (shift_q == 8'hF0)
                     brk_d = 1'b1;
                  else begin
                     code_d = shift_q;
                     flag_d = 1'b1;
                  end
`else
                  code_d = shift_q;
                  flag_d = 1'b1;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE && !fall_q && tmo_q == TW'(TIMEOUT_CYCLES))
         state_d = S_IDLE;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         clk_f_q  <= 1'b1;
         fall_q   <= 1'b0;
         deb_q    <= 8'd0;
         state_q  <= S_IDLE;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         par_ok_q <= 1'b0;
         tmo_q    <= '0;
         code_q   <= 8'h00;
         flag_q   <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
         brk_q    <= 1'b0;
`endif
      end else begin
         clk_f_q  <= clk_f_d;
         fall_q   <= fall_d;
         deb_q    <= deb_d;
         state_q  <= state_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_ok_q <= par_ok_d;
         tmo_q    <= tmo_d;
         code_q   <= code_d;
         flag_q   <= flag_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
`ifdef PS2_BREAK_FILTER_EN
         brk_q    <= brk_d;
`endif
      end
   end

   assign kbd.scancode   = code_q;
   assign kbd.flag       = flag_q;
   assign kbd.parity_err = perr_q;
   assign kbd.frame_err  = ferr_q;

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver that feeds the scancode decoder. It samples the raw keyboard `ps2_clk`/`ps2_data` lines in the `vga_clk` domain, filters glitches, deframes 11-bit PS/2 frames, and checks parity and stop bits. Each good byte is presented on `scancode` with a one-cycle `flag` strobe, which matches the decoder's `scancode`/`flag` inputs directly. An optional filter can swallow key-release (break) sequences, so that only make codes reach the decoder.

## Interface
- `DEBOUNCE_CYCLES`, default 8: the `vga_clk` cycles the synchronized `ps2_clk` must stay stable before the filtered clock changes (legal range 2–255).
- `TIMEOUT_CYCLES`, default 25000: the idle limit inside a frame before the FSM aborts it. The default is 1 ms at 25 MHz.
- `vga_clk`, input, 1 bit: system/pixel clock (25 MHz nominal).
- `reset`, input, 1 bit: asynchronous, active-high.
- `ps2_clk`, input, 1 bit: raw keyboard clock (asynchronous).
- `ps2_data`, input, 1 bit: raw keyboard data (asynchronous).
- `scancode`, output, 8 bits: last accepted byte; it holds its value until the next accepted byte.
- `flag`, output, 1 bit: one-cycle strobe marking a new `scancode`.
- `parity_err`, output, 1 bit: one-cycle strobe for a frame with bad odd parity.
- `frame_err`, output, 1 bit: one-cycle strobe for a frame whose stop bit is 0.

## Operation
- **Synchronizers:** `ps2_clk` and `ps2_data` each pass through 2 flip-flops (`clk_s`, `dat_s`).
- **Glitch filter:** the filtered clock `clk_f` takes the value of `clk_s` only after `clk_s` has differed from `clk_f` for `DEBOUNCE_CYCLES` consecutive cycles.
  - The filter counter clears whenever `clk_s` equals `clk_f`.
  - `fall` is a 1-cycle pulse when `clk_f` goes from 1 to 0.
- **Sampling:** every bit is sampled from `dat_s` in the cycle `fall` is high.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with `dat_s`=0 (start bit), go to DATA and set the bit count to 0. If `dat_s`=1, stay in IDLE and report no error.
  - DATA: on each `fall`, shift `dat_s` into bit[count]. Bits arrive LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, compute ok = (XOR of the 8 data bits XOR `dat_s`) == 1, i.e. odd parity. Store ok and go to STOP.
  - STOP: on `fall`, return to IDLE and resolve the frame:
    - `dat_s`=0: pulse `frame_err`. This takes priority over the parity result.
    - otherwise, parity bad: pulse `parity_err`.
    - otherwise: the byte is accepted.
- **Accepted byte:** load `scancode` and pulse `flag`, subject to the break filter (see Configuration).
- **Timeout:** a counter clears on every `fall` and increments in every non-IDLE state.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE.
  - No strobe is issued and `scancode` is unchanged.
  - The counter saturates and never wraps.
- **Reset (asynchronous, any time, including mid-frame):**
  - FSM goes to IDLE; all counters and the shift register clear to 0.
  - `clk_f` and both synchronizer stages go to 1.
  - `scancode`=8'h00, `flag`=0, `parity_err`=0, `frame_err`=0, break-pending=0.

## Timing
- All outputs are registered.
- The `flag`/`parity_err`/`frame_err` strobe is asserted exactly 1 `vga_clk` cycle after the `fall` that samples the stop bit, and lasts exactly 1 cycle.
- `scancode` changes in the same cycle that `flag` rises.
- Latency from the raw stop-bit falling edge to `flag`: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles. With defaults this is 11 cycles.
- At most one strobe per frame. `flag`, `parity_err` and `frame_err` are never high together.
- A PS/2 bit period (60–100 µs, ≥1500 cycles) is far longer than the full pipeline, so no back-pressure exists and the downstream block must take each `flag` on sight.

## Configuration
- Macro `PS2_BREAK_FILTER_EN`.
- **Defined:** an accepted byte 8'hF0 sets break-pending and does not strobe `flag`. The next accepted byte clears break-pending and also does not strobe `flag`. `scancode` is unchanged in both cases.
  - Parity, frame and timeout errors do not alter break-pending.
  - Reset clears break-pending.
- **Undefined:** every accepted byte, including 8'hF0, loads `scancode` and strobes `flag`. No break-pending register exists.

## Test plan
- **Valid frame:** send 8'h2B (start 0, data 1,1,0,1,0,1,0,0, parity 1, stop 1) -> one 1-cycle `flag`, `scancode`=8'h2B; `parity_err`=`frame_err`=0.
- **Parity error:** send 8'h15 with parity bit 1 (odd parity requires 0) -> one `parity_err` pulse, no `flag`, `scancode` keeps its previous value 8'h2B.
- **Break filter:** send 8'hF0, 8'h2B, 8'h33.
  - Macro defined -> exactly one `flag`, with `scancode`=8'h33.
  - Macro undefined -> three `flag`s carrying F0, 2B, 33 in order.
- **Glitch rejection:** insert a 3-cycle low pulse on `ps2_clk` while idle, then send 8'h34 -> no strobe for the glitch; one `flag` with `scancode`=8'h34.
- **Timeout recovery:** send start + 4 data bits, hold `ps2_clk` high for `TIMEOUT_CYCLES`+10 cycles, then send 8'h32 -> no strobe for the partial frame; one `flag` with `scancode`=8'h32.
- **Reset mid-frame:** assert `reset` after the 5th data bit of 8'h23 -> all outputs 0 immediately (asynchronous). After release, a full 8'h44 frame -> `flag` with `scancode`=8'h44.
